apb_i2c_ctrl: RTL and testbench
===============================

# apb_i2c_ctrl

APB3 slave front-end of the APB-to-I2C bridge. It holds the software-visible register file and sequences one I2C transfer per START command into the downstream I2C master: it drives enable, rw, slave address, write data and byte count, and watches the master's `ready`. After a read transfer it walks the master's byte index and packs the received bytes into a 32-bit RXDATA register.

## Interface
Parameters:
- `REQ_TIMEOUT`, default 15: maximum number of cycles to wait for master `ready` to fall after `mst_enable` is asserted.

Ports:
- `clk`  in  1  single clock for the APB side and the master handshake.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `psel`, `penable`, `pwrite`  in  1 each  APB control.
- `paddr`  in  5  byte address; bits [4:2] are decoded.
- `pwdata`  in  32  write data.
- `prdata`  out  32  read data.
- `pready`  out  1  tied to 1 (zero wait states).
- `pslverr`  out  1  error response.
- `irq`  out  1  equal to `DONE & IE`.
- `mst_enable`  out  1  start request to the master.
- `mst_rw`  out  1  1 = read.
- `mst_addr`  out  7  I2C slave address.
- `mst_din`  out  32  write bytes; [31:24] is sent first.
- `mst_bytcount`  out  2  number of bytes minus 1.
- `mst_i`  out  2  byte index used for readback.
- `mst_ready`  in  1  master idle/stop indication.
- `mst_data`  in  8  master byte at index `mst_i`. This is combinational in `mst_i`.

## Operation
Register map (`paddr[4:2]`):
- 0x00 CTRL (RW):
  - bit0 START: write-1 starts a transfer; it self-clears and always reads 0.
  - bit1 RW.
  - [3:2] BYTCNT.
  - bit4 IE.
- 0x04 SADDR (RW): bits [6:0].
- 0x08 TXDATA (RW): 32 bits.
- 0x0C RXDATA (RO).
- 0x10 STATUS:
  - bit0 BUSY (RO).
  - bit1 DONE (W1C).
  - bit2 ERR (W1C).
- All other offsets are unmapped.

APB access rules:
- A write takes effect in the access phase (`psel & penable & pwrite`).
- `prdata` = the selected register when `psel & ~pwrite`, otherwise 0. Unmapped offsets read 0.
- `pslverr` is asserted in the access phase, and the errored write has no effect, for any of:
  - an unmapped offset;
  - a write to RXDATA;
  - a write to CTRL, SADDR or TXDATA while BUSY = 1.

Outputs `mst_rw`, `mst_addr`, `mst_din`, `mst_bytcount` come directly from CTRL.RW, SADDR, TXDATA and CTRL.BYTCNT. Because those registers are write-protected while BUSY, the outputs are stable for the whole transfer.

FSM:
- **S_IDLE**: BUSY = 0. A CTRL write with START = 1 does the following, then the FSM goes to S_REQ:
  - clears DONE and ERR;
  - if RW = 1, clears RXDATA to 0;
  - loads the timeout counter with 0.
- **S_REQ**: `mst_enable` = 1; the timeout counter increments each cycle.
  - If `mst_ready` = 0, go to S_WAIT.
  - Otherwise, if the counter reaches `REQ_TIMEOUT`, set ERR and DONE and go to S_IDLE.
- **S_WAIT**: `mst_enable` = 0. On `mst_ready` = 1:
  - if RW = 0, set DONE and go to S_IDLE;
  - if RW = 1, set idx = 0 and go to S_RDSEL.
- **S_RDSEL**: `mst_i` = idx; go to S_RDCAP.
- **S_RDCAP**: `mst_i` = idx; capture `mst_data` into RXDATA byte lane [31-8·idx -: 8].
  - If idx == BYTCNT, set DONE and go to S_IDLE.
  - Otherwise idx++ and go to S_RDSEL.
- BUSY = 1 in every state except S_IDLE.
- `mst_enable` must never be high in S_WAIT. This prevents the master from re-starting once it returns to idle.

Boundary conditions:
- **W1C while DONE is being set:** a software write-1 to clear DONE in the same cycle that the FSM sets DONE leaves DONE = 1. The set wins.
- **START together with other CTRL fields:** RW, BYTCNT and IE from the same write are used for that transfer.
- **Reset mid-transfer:** the FSM goes to S_IDLE, `mst_enable` drops next cycle, all registers are cleared. The I2C master must be reset in the same cycle.

## Timing
- Reset values:
  - all registers 0;
  - `mst_enable` = 0, `mst_i` = 0;
  - `prdata` = 0, `pslverr` = 0, `irq` = 0;
  - `pready` = 1.
- START write to `mst_enable` high: 1 cycle (registered).
- `mst_enable` is held until the first cycle with `mst_ready` = 0.
- `mst_ready` rising edge to DONE:
  - write transfer: 1 cycle;
  - read transfer: 1 + 2·(BYTCNT+1) cycles.
- `irq` is combinational from the registered DONE and IE bits.

## Structure
- Shared package `apb_i2c_pkg` holds:
  - register offsets (CTRL, SADDR, TXDATA, RXDATA, STATUS);
  - CTRL and STATUS bit positions;
  - FSM state encoding.
- Natural split: sub-module `apb_i2c_regs` (decode, register file, pslverr), with the FSM in the top level. A single module is also acceptable.

## Test plan
1. **Reset values.** Assert `rst` for 2 cycles. Then every output is at its reset value, and reads of all five offsets return 0.
2. **Two-byte write.** Write SADDR = 0x50, TXDATA = 0xA5C30000, CTRL = 0x15 (START, BYTCNT = 1, IE). Required response:
   - `mst_addr` = 0x50, `mst_din` = 0xA5C30000, `mst_bytcount` = 1, `mst_rw` = 0;
   - `mst_enable` high until the model drops `ready`;
   - after `ready` returns, STATUS = 0x2 and `irq` = 1.
3. **Four-byte read.** The model returns 0x11, 0x22, 0x33, 0x44 for `mst_i` = 0..3. Write CTRL = 0x0F. Required response: `mst_i` steps 0, 1, 2, 3; RXDATA = 0x11223344; DONE = 1.
4. **One-byte read after an earlier read.** RXDATA previously held a nonzero value; model byte 0 = 0xAB. Required response: RXDATA = 0xAB000000.
5. **Write while busy, then unmapped read.** Write TXDATA while BUSY → `pslverr` = 1 and TXDATA is unchanged. Read offset 0x14 → `pslverr` = 1 and `prdata` = 0.
6. **Timeout, then reset mid-transfer.**
   - Hold `mst_ready` = 1 after START → after `REQ_TIMEOUT` cycles, `mst_enable` = 0 and STATUS = 0x6.
   - Assert `rst` during S_WAIT → `mst_enable` = 0 and BUSY = 0 on the next cycle.

Source files
------------

// File: rtl/apb_i2c_pkg.sv
// Shared register map, bit positions and FSM encoding for the APB-to-I2C front-end.
package apb_i2c_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_SADDR  = 3'd1;
  localparam logic [2:0] OFF_TXDATA = 3'd2;
  localparam logic [2:0] OFF_RXDATA = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_RW     = 1;
  localparam int CTRL_BYTCNT = 2;
  localparam int CTRL_IE     = 4;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_ERR  = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_RDSEL = 3'd3,
    S_RDCAP = 3'd4
  } fsm_state_t;

endpackage

// File: rtl/apb_i2c_regs.sv
// APB decode, software register file and error response for the I2C bridge.
module apb_i2c_regs
  import apb_i2c_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [4:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pslverr,
  input  logic        busy,
  input  logic        done_set,
  input  logic        err_set,
  input  logic        rx_we,
  input  logic [1:0]  rx_lane,
  input  logic [7:0]  rx_byte,
  output logic        start,
  output logic        ctrl_rw,
  output logic [1:0]  ctrl_bytcnt,
  output logic        ctrl_ie,
  output logic [6:0]  saddr,
  output logic [31:0] txdata,
  output logic        done
);

  logic [2:0]  off_s;
  logic        access_s;
  logic        err_s;
  logic        wr_ok_s;
  logic        w1c_s;
  logic [31:0] rd_s;
  logic        ctrl_rw_r;
  logic [1:0]  ctrl_bytcnt_r;
  logic        ctrl_ie_r;
  logic [6:0]  saddr_r;
  logic [31:0] tx_r;
  logic [31:0] rx_r;
  logic        done_r;
  logic        err_r;
  logic        unused_s;

  assign unused_s = &{1'b0, paddr[1:0]};
  assign off_s    = paddr[4:2];
  assign access_s = psel & penable;
  // Config registers are frozen while a transfer runs so the master sees stable inputs.
  assign err_s    = access_s & ((off_s > OFF_STATUS) |
                    (pwrite & ((off_s == OFF_RXDATA) |
                    (busy & ((off_s == OFF_CTRL) | (off_s == OFF_SADDR) | (off_s == OFF_TXDATA))))));
  assign wr_ok_s  = access_s & pwrite & ~err_s;
  assign w1c_s    = wr_ok_s & (off_s == OFF_STATUS);
  assign start    = wr_ok_s & (off_s == OFF_CTRL) & pwdata[CTRL_START];
  assign pslverr  = err_s;

  // Register file updates from APB writes and FSM status/readback events.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_rw_r     <= 1'b0;
      ctrl_bytcnt_r <= 2'd0;
      ctrl_ie_r     <= 1'b0;
      saddr_r       <= 7'd0;
      tx_r          <= 32'd0;
      rx_r          <= 32'd0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      if (wr_ok_s && off_s == OFF_CTRL) begin
        ctrl_rw_r     <= pwdata[CTRL_RW];
        ctrl_bytcnt_r <= pwdata[CTRL_BYTCNT +: 2];
        ctrl_ie_r     <= pwdata[CTRL_IE];
      end
      if (wr_ok_s && off_s == OFF_SADDR) saddr_r <= pwdata[6:0];
      if (wr_ok_s && off_s == OFF_TXDATA) tx_r <= pwdata;
      done_r <= start ? 1'b0 : ((done_r & ~(w1c_s & pwdata[STATUS_DONE])) | done_set);
      err_r  <= start ? 1'b0 : ((err_r & ~(w1c_s & pwdata[STATUS_ERR])) | err_set);
      if (start && pwdata[CTRL_RW]) begin
        rx_r <= 32'd0;
      end else if (rx_we) begin
        case (rx_lane)
          2'd0:    rx_r[31:24] <= rx_byte;
          2'd1:    rx_r[23:16] <= rx_byte;
          2'd2:    rx_r[15:8]  <= rx_byte;
          default: rx_r[7:0]   <= rx_byte;
        endcase
      end
    end
  end

  // Read mux for the selected offset.
  always_comb begin
    rd_s = 32'd0;
    case (off_s)
      OFF_CTRL: begin
        rd_s[CTRL_RW]           = ctrl_rw_r;
        rd_s[CTRL_BYTCNT +: 2]  = ctrl_bytcnt_r;
        rd_s[CTRL_IE]           = ctrl_ie_r;
      end
      OFF_SADDR:  rd_s = {25'd0, saddr_r};
      OFF_TXDATA: rd_s = tx_r;
      OFF_RXDATA: rd_s = rx_r;
      OFF_STATUS: begin
        rd_s[STATUS_BUSY] = busy;
        rd_s[STATUS_DONE] = done_r;
        rd_s[STATUS_ERR]  = err_r;
      end
      default: rd_s = 32'd0;
    endcase
  end

  assign prdata      = (psel & ~pwrite) ? rd_s : 32'd0;
  assign ctrl_rw     = ctrl_rw_r;
  assign ctrl_bytcnt = ctrl_bytcnt_r;
  assign ctrl_ie     = ctrl_ie_r;
  assign saddr       = saddr_r;
  assign txdata      = tx_r;
  assign done        = done_r;

endmodule

// File: rtl/apb_i2c_ctrl.sv
// APB3 front-end of the APB-to-I2C bridge: register file plus the transfer sequencer
// that starts the I2C master and gathers read bytes into RXDATA.
module apb_i2c_ctrl
  import apb_i2c_pkg::*;
#(
  parameter int REQ_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [4:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        irq,
  output logic        mst_enable,
  output logic        mst_rw,
  output logic [6:0]  mst_addr,
  output logic [31:0] mst_din,
  output logic [1:0]  mst_bytcount,
  output logic [1:0]  mst_i,
  input  logic        mst_ready,
  input  logic [7:0]  mst_data
);

  localparam int CNT_W = $clog2(REQ_TIMEOUT + 1);

  fsm_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;
  logic             en_r;
  logic             start_s;
  logic             busy_s;
  logic             done_s;
  logic             ie_s;
  logic             timeout_s;
  logic             wr_done_s;
  logic             rd_last_s;
  logic             done_set_s;
  logic             rx_we_s;

  assign busy_s     = (state_r != S_IDLE);
  assign timeout_s  = (state_r == S_REQ) & mst_ready & (cnt_r == CNT_W'(REQ_TIMEOUT - 1));
  assign wr_done_s  = (state_r == S_WAIT) & mst_ready & ~mst_rw;
  assign rd_last_s  = (state_r == S_RDCAP) & (idx_r == mst_bytcount);
  assign done_set_s = timeout_s | wr_done_s | rd_last_s;
  assign rx_we_s    = (state_r == S_RDCAP);

  apb_i2c_regs u_regs (
    .clk         (clk),
    .rst         (rst),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pslverr     (pslverr),
    .busy        (busy_s),
    .done_set    (done_set_s),
    .err_set     (timeout_s),
    .rx_we       (rx_we_s),
    .rx_lane     (idx_r),
    .rx_byte     (mst_data),
    .start       (start_s),
    .ctrl_rw     (mst_rw),
    .ctrl_bytcnt (mst_bytcount),
    .ctrl_ie     (ie_s),
    .saddr       (mst_addr),
    .txdata      (mst_din),
    .done        (done_s)
  );

  // Transfer sequencer; mst_enable is dropped on leaving S_REQ so it is never seen in S_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
      idx_r   <= 2'd0;
      en_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_s) begin
            state_r <= S_REQ;
            cnt_r   <= '0;
            en_r    <= 1'b1;
          end
        end
        S_REQ: begin
          if (!mst_ready) begin
            state_r <= S_WAIT;
            en_r    <= 1'b0;
          end else if (timeout_s) begin
            state_r <= S_IDLE;
            en_r    <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (mst_ready) begin
            idx_r   <= 2'd0;
            state_r <= mst_rw ? S_RDSEL : S_IDLE;
          end
        end
        S_RDSEL: state_r <= S_RDCAP;
        S_RDCAP: begin
          if (rd_last_s) begin
            idx_r   <= 2'd0;
            state_r <= S_IDLE;
          end else begin
            idx_r   <= idx_r + 2'd1;
            state_r <= S_RDSEL;
          end
        end
        default: begin
          state_r <= S_IDLE;
          en_r    <= 1'b0;
        end
      endcase
    end
  end

  assign mst_enable = en_r;
  assign mst_i      = idx_r;
  assign pready     = 1'b1;
  assign irq        = done_s & ie_s;

endmodule

// File: tb/tb_apb_i2c_ctrl.sv
// Directed bench for apb_i2c_ctrl: APB responses go through a scoreboard queue checked
// by a monitor; master-side behaviour is checked against hand-computed values.
module tb_apb_i2c_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, irq;
  logic        mst_enable, mst_rw;
  logic [6:0]  mst_addr;
  logic [31:0] mst_din;
  logic [1:0]  mst_bytcount, mst_i;
  logic        mst_ready;
  logic [7:0]  mst_data;
  logic [7:0]  rd_bytes [4];

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  assign mst_data = rd_bytes[mst_i];

  apb_i2c_ctrl #(.REQ_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .irq(irq), .mst_enable(mst_enable), .mst_rw(mst_rw),
    .mst_addr(mst_addr), .mst_din(mst_din), .mst_bytcount(mst_bytcount),
    .mst_i(mst_i), .mst_ready(mst_ready), .mst_data(mst_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every APB access phase pops one expected response.
  always @(negedge clk) begin
    if (psel && penable) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_access", {27'd0, paddr}, 32'h0000_00ff);
      end else begin
        mon_e = exp_q.pop_front();
        chk("prdata", prdata, mon_e.data);
        chk("pslverr", {31'd0, pslverr}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d, input logic e,
                           input logic raise_rdy);
    exp_t x;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    tick(1);
    penable = 1'b1;
    if (raise_rdy) mst_ready = 1'b1;
    x.data = 32'd0; x.err = e;
    exp_q.push_back(x);
    tick(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, input logic [31:0] d, input logic e);
    exp_t x;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a; pwdata = 32'd0;
    tick(1);
    penable = 1'b1;
    x.data = d; x.err = e;
    exp_q.push_back(x);
    tick(1);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 5'd0; pwdata = 32'd0; mst_ready = 1'b1;
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
    tick(2);
    rst = 1'b0;

    // Reset values
    chk("rst_mst_enable", {31'd0, mst_enable}, 32'd0);
    chk("rst_mst_i", {30'd0, mst_i}, 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pready", {31'd0, pready}, 32'd1);
    for (int i = 0; i < 5; i++) apb_read(5'(i * 4), 32'd0, 1'b0);

    // Two-byte write
    apb_write(5'h04, 32'h0000_0050, 1'b0, 1'b0);
    apb_write(5'h08, 32'hA5C3_0000, 1'b0, 1'b0);
    apb_write(5'h00, 32'h0000_0015, 1'b0, 1'b0);
    chk("wr_en_after_start", {31'd0, mst_enable}, 32'd1);
    chk("wr_mst_addr", {25'd0, mst_addr}, 32'h50);
    chk("wr_mst_din", mst_din, 32'hA5C3_0000);
    chk("wr_mst_bytcount", {30'd0, mst_bytcount}, 32'd1);
    chk("wr_mst_rw", {31'd0, mst_rw}, 32'd0);
    tick(2);
    chk("wr_en_held", {31'd0, mst_enable}, 32'd1);
    mst_ready = 1'b0;
    tick(1);
    chk("wr_en_dropped", {31'd0, mst_enable}, 32'd0);
    apb_read(5'h10, 32'h1, 1'b0);
    chk("wr_en_low_in_wait", {31'd0, mst_enable}, 32'd0);
    mst_ready = 1'b1;
    tick(1);
    chk("wr_irq_done", {31'd0, irq}, 32'd1);
    apb_read(5'h10, 32'h2, 1'b0);
    apb_read(5'h00, 32'h14, 1'b0);

    // Four-byte read
    apb_write(5'h00, 32'h0000_000F, 1'b0, 1'b0);
    chk("rd4_irq_cleared", {31'd0, irq}, 32'd0);
    mst_ready = 1'b0;
    tick(1);
    mst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk("rd4_mst_i_sel", {30'd0, mst_i}, 32'(k));
      tick(1);
      chk("rd4_mst_i_cap", {30'd0, mst_i}, 32'(k));
    end
    tick(1);
    chk("rd4_irq_ie0", {31'd0, irq}, 32'd0);
    apb_read(5'h0C, 32'h1122_3344, 1'b0);
    apb_read(5'h10, 32'h2, 1'b0);

    // One-byte read after an earlier read
    rd_bytes[0] = 8'hAB;
    apb_write(5'h00, 32'h0000_0013, 1'b0, 1'b0);
    apb_read(5'h0C, 32'd0, 1'b0);
    mst_ready = 1'b0;
    tick(1);
    mst_ready = 1'b1;
    tick(2);
    chk("rd1_irq_early", {31'd0, irq}, 32'd0);
    tick(1);
    chk("rd1_irq_on_time", {31'd0, irq}, 32'd1);
    apb_read(5'h0C, 32'hAB00_0000, 1'b0);

    // Writes while busy and unmapped offsets
    apb_write(5'h00, 32'h0000_0001, 1'b0, 1'b0);
    apb_write(5'h08, 32'h1234_5678, 1'b1, 1'b0);
    apb_write(5'h00, 32'h0000_000F, 1'b1, 1'b0);
    mst_ready = 1'b0;
    tick(1);
    mst_ready = 1'b1;
    tick(1);
    chk("busy_wr_rw_kept", {31'd0, mst_rw}, 32'd0);
    apb_read(5'h08, 32'hA5C3_0000, 1'b0);
    apb_read(5'h00, 32'h0, 1'b0);
    apb_read(5'h14, 32'd0, 1'b1);
    apb_write(5'h1C, 32'hFFFF_FFFF, 1'b1, 1'b0);
    apb_write(5'h0C, 32'h5555_5555, 1'b1, 1'b0);
    apb_read(5'h0C, 32'hAB00_0000, 1'b0);
    apb_write(5'h10, 32'h2, 1'b0, 1'b0);
    apb_read(5'h10, 32'h0, 1'b0);

    // Timeout with ready held high
    apb_write(5'h00, 32'h0000_0011, 1'b0, 1'b0);
    tick(14);
    chk("to_en_still_high", {31'd0, mst_enable}, 32'd1);
    tick(1);
    chk("to_en_dropped", {31'd0, mst_enable}, 32'd0);
    chk("to_irq", {31'd0, irq}, 32'd1);
    apb_read(5'h10, 32'h6, 1'b0);

    // W1C of DONE in the same cycle the FSM sets it: set wins
    apb_write(5'h00, 32'h0000_0001, 1'b0, 1'b0);
    mst_ready = 1'b0;
    tick(1);
    apb_write(5'h10, 32'h2, 1'b0, 1'b1);
    apb_read(5'h10, 32'h2, 1'b0);

    // Reset during S_REQ and during S_WAIT
    apb_write(5'h00, 32'h0000_0001, 1'b0, 1'b0);
    chk("rst_req_en_before", {31'd0, mst_enable}, 32'd1);
    rst = 1'b1;
    tick(1);
    chk("rst_req_en_after", {31'd0, mst_enable}, 32'd0);
    rst = 1'b0;
    apb_write(5'h08, 32'hDEAD_BEEF, 1'b0, 1'b0);
    apb_write(5'h00, 32'h0000_0001, 1'b0, 1'b0);
    mst_ready = 1'b0;
    tick(1);
    apb_read(5'h10, 32'h1, 1'b0);
    rst = 1'b1;
    tick(1);
    chk("rst_wait_en", {31'd0, mst_enable}, 32'd0);
    rst = 1'b0;
    mst_ready = 1'b1;
    apb_read(5'h10, 32'h0, 1'b0);
    apb_read(5'h08, 32'h0, 1'b0);
    apb_read(5'h04, 32'h0, 1'b0);

    tick(2);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
